// File: rtl/slew_real_pkg.sv
// Shared types and constants for the slew_real fixed-point slew-rate limiter.
package slew_real_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  // Extra bit above out_width so distances between any two targets never wrap.
  localparam int GUARD_BITS = 1;

  // Quantize a real constant to an integer count of 2^exponent LSBs, truncating toward -inf.
  function automatic longint quantize(input real value, input int exponent);
    real    scaled;
    longint trunc;
    scaled = value;
    if (exponent < 0) begin
      for (int i = 0; i < -exponent; i++) scaled = scaled * 2.0;
    end else begin
      for (int i = 0; i < exponent; i++) scaled = scaled / 2.0;
    end
    trunc = longint'($rtoi(scaled));
    if (real'(trunc) > scaled) trunc = trunc - 1;
    return trunc;
  endfunction

endpackage

// File: rtl/slew_real_align.sv
// Combinational fixed-point format conversion: shift by the exponent difference, then
// sign-extend or truncate to the destination width. Right shifts round toward -inf.
module slew_real_align #(
  parameter int src_width    = 16,
  parameter int src_exponent = -8,
  parameter int dst_width    = 16,
  parameter int dst_exponent = -8
) (
  input  logic signed [src_width-1:0] src,
  output logic signed [dst_width-1:0] dst
);

  localparam int SHIFT   = src_exponent - dst_exponent;
  localparam int LSHIFT  = (SHIFT > 0) ? SHIFT : 0;
  localparam int RSHIFT  = (SHIFT < 0) ? -SHIFT : 0;
  localparam int WIDE    = ((src_width + LSHIFT) > dst_width) ? (src_width + LSHIFT) : dst_width;

  logic signed [WIDE-1:0] ext;
  logic signed [WIDE-1:0] shifted;

  assign ext     = WIDE'(src);
  assign shifted = (SHIFT >= 0) ? (ext <<< LSHIFT) : (ext >>> RSHIFT);
  assign dst     = shifted[dst_width-1:0];

endmodule

// File: rtl/slew_real.sv
// Fixed-point slew-rate limiter: ramps a registered output toward an accepted target by at
// most one step per enabled clock. Define SLEW_REAL_ABORT_EN to add the abort input.
module slew_real
  import slew_real_pkg::*;
#(
  parameter real init         = 0.0,
  parameter real step         = 1.0,
  parameter int  in_width     = 16,
  parameter int  in_exponent  = -8,
  parameter int  out_width    = 16,
  parameter int  out_exponent = -8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [in_width-1:0]  in,
  input  logic                        in_valid,
  output logic                        in_ready,
`ifdef SLEW_REAL_ABORT_EN
  input  logic                        abort,
`endif
  input  logic                        ce,
  output logic signed [out_width-1:0] out,
  output logic                        busy,
  output logic                        done
);

  localparam int     AW       = out_width + GUARD_BITS;
  localparam longint INIT_Q   = quantize(init, out_exponent);
  localparam longint STEP_RAW = quantize(step, out_exponent);
  // A step that quantizes to zero would stall the ramp forever, so it becomes one LSB.
  localparam longint STEP_Q   = (STEP_RAW < 1) ? 64'sd1 : STEP_RAW;

  localparam logic signed [out_width-1:0] INIT_V = out_width'(INIT_Q);
  localparam logic signed [AW-1:0]        STEP_V = AW'(STEP_Q);

  state_t                      state;
  logic signed [out_width-1:0] tgt;
  logic signed [out_width-1:0] in_al;
  logic signed [AW-1:0]        up_dist;
  logic signed [AW-1:0]        dn_dist;
  logic signed [AW-1:0]        up_next;
  logic signed [AW-1:0]        dn_next;

  slew_real_align #(
    .src_width    (in_width),
    .src_exponent (in_exponent),
    .dst_width    (out_width),
    .dst_exponent (out_exponent)
  ) u_align (
    .src (in),
    .dst (in_al)
  );

  assign up_dist = AW'(tgt) - AW'(out);
  assign dn_dist = AW'(out) - AW'(tgt);
  assign up_next = AW'(out) + STEP_V;
  assign dn_next = AW'(out) - STEP_V;

  assign busy     = (state != IDLE);
  assign in_ready = ~busy;

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      out   <= INIT_V;
      tgt   <= INIT_V;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            tgt <= in_al;
            if (in_al > out)      state <= UP;
            else if (in_al < out) state <= DOWN;
            else                  done  <= 1'b1;
          end
        end
        UP: begin
`ifdef SLEW_REAL_ABORT_EN
          if (abort) begin
            state <= IDLE;
          end else
`endif
          if (ce) begin
            if (up_dist <= STEP_V) begin
              out   <= tgt;
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              out <= up_next[out_width-1:0];
            end
          end
        end
        DOWN: begin
`ifdef SLEW_REAL_ABORT_EN
          if (abort) begin
            state <= IDLE;
          end else
`endif
          if (ce) begin
            if (dn_dist <= STEP_V) begin
              out   <= tgt;
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              out <= dn_next[out_width-1:0];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
